dma_io_peripheral: RTL and testbench
====================================

# dma_io_peripheral

Single-channel DMA-capable I/O peripheral model: the device end of the DREQ/DACK/IOR_N/IOW_N/EOP_N handshake driven by the DMA controller's timing-and-control block. It buffers bytes in an internal FIFO, raises DREQ when the buffer crosses a threshold, moves one byte per I/O strobe while DACK is high, and stops on EOP_N. It serves as synthesizable stimulus/responder for controller integration benches, and as a reference peripheral.

## Interface
- DEPTH, 16: FIFO depth in bytes (power of two, >= 4).
- THRESHOLD, 4: fill level (dev->mem) or free space (mem->dev) that raises DREQ; 1..DEPTH.
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  channel enable; low forces IDLE.
- devToMem  in  1  1 = device->memory (DMA write, IOR_N strobes); 0 = memory->device (DMA read, IOW_N strobes). Sampled only in IDLE.
- DREQ  out  1  DMA request to controller.
- DACK  in  1  DMA acknowledge for this channel.
- IOR_N  in  1  I/O read strobe, active low.
- IOW_N  in  1  I/O write strobe, active low.
- EOP_N  in  1  end of process, active low.
- DB_IN  in  8  data bus from controller/memory side.
- DB_OUT  out  8  data bus toward memory side.
- DB_OE  out  1  DB_OUT valid/drive enable.
- lclWrData  in  8 / lclWrValid  in  1 / lclWrReady  out  1  local producer (dev->mem).
- lclRdData  out  8 / lclRdValid  out  1 / lclRdReady  in  1  local consumer (mem->dev).
- tcSeen  out  1  sticky: EOP_N observed with DACK.
- xferErr  out  1  sticky: strobe on empty (read) or full (write) FIFO.

## Operation
- States: IDLE, REQUEST, ACTIVE, DONE.
- IDLE: DREQ=0. Latch devToMem. If enable and level condition met (dev->mem: count >= THRESHOLD; mem->dev: DEPTH-count >= THRESHOLD) -> REQUEST.
- REQUEST: DREQ=1. DACK=1 -> ACTIVE. enable=0 -> IDLE.
- ACTIVE: DREQ=1 until stop condition. Strobe = falling edge of IOR_N (dev->mem) or IOW_N (mem->dev), detected against a registered previous sample, qualified by DACK=1.
  - dev->mem strobe: capture FIFO head into DB_OUT register, pop. DB_OE = DACK & ~IOR_N & devToMem, registered.
  - mem->dev strobe: push DB_IN.
  - Stop: EOP_N=0 with DACK=1 -> set tcSeen, -> DONE. FIFO empty (dev->mem) or full (mem->dev) after a strobe -> IDLE. DACK dropped without EOP -> REQUEST if level condition still met, else IDLE.
- DONE: DREQ=0; stays until enable=0, then IDLE. tcSeen cleared only by RESET.
- Strobe on empty/full: no pop/push, DB_OUT unchanged, xferErr=1.
- Local side active in every state: lclWrReady = ~full when devToMem, else 0; lclRdValid = ~empty when ~devToMem; lclRdData = FIFO head. Handshake fires when valid & ready.
- Simultaneous push and pop in one cycle: both occur, count unchanged. Push on full or pop on empty never happens.
- Wrong-direction strobe (IOW_N in dev->mem, etc.) ignored.

## Timing
- Reset values: DREQ=0, DB_OUT=8'h00, DB_OE=0, lclWrReady=0, lclRdValid=0, tcSeen=0, xferErr=0, state IDLE, FIFO empty, previous-strobe registers=1.
- IDLE->REQUEST: DREQ high 1 cycle after level condition becomes true.
- DACK high at edge N -> state ACTIVE at N+1.
- Strobe low first sampled at edge N -> pop/push at N; DB_OUT valid and DB_OE high from N+1 while strobe low. Holding a strobe low for many cycles = one transfer.
- EOP_N sampled at edge N -> DREQ low from N+1.
- FIFO count updates at the strobe edge; level condition is re-evaluated on the new count next cycle.
- RESET mid-transfer: all state cleared next edge, FIFO contents discarded, DREQ low immediately after.

## Structure
- Package dma_periph_pkg: state enum (IDLE, REQUEST, ACTIVE, DONE), direction constants DIR_DEV2MEM/DIR_MEM2DEV, data width constant 8.
- Sub-module sync_fifo (parameterized DEPTH, width 8; push/pop/full/empty/count, log2(DEPTH)+1-bit count, wrap-around pointers).
- Top holds FSM, edge detectors, DB_OUT register, sticky flags.

## Test plan
- Dev->mem: push 4 bytes 8'hA0..A3 locally, THRESHOLD=4 -> DREQ=1 next cycle; DACK=1, four IOR_N pulses -> DB_OUT A0,A1,A2,A3, FIFO empty, DREQ=0, state IDLE.
- Mem->dev: DEPTH=16 empty, devToMem=0 -> DREQ=1; three IOW_N pulses with DB_IN 11,22,33, then EOP_N=0 -> tcSeen=1, DREQ=0, lclRdData=11 then 22, 33 as lclRdReady drains.
- IOR_N held low 5 cycles -> exactly one pop; count drops by 1.
- IOR_N strobe with FIFO empty under DACK -> xferErr=1, count stays 0, DB_OUT unchanged.
- RESET during ACTIVE after 2 of 4 transfers -> DREQ=0, count=0, tcSeen=0 next cycle.
- DACK dropped mid-block with 6 bytes left, THRESHOLD=4 -> REQUEST, DREQ stays 1; re-DACK resumes at next byte in order.

Source files
------------

// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the DMA I/O peripheral.
package dma_periph_pkg;

  localparam int DATA_W = 8;

  // Direction encoding for the latched devToMem input.
  localparam logic DIR_DEV2MEM = 1'b1;
  localparam logic DIR_MEM2DEV = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with wrap-around pointers and an occupancy count one bit wider
// than the pointers so full and empty are distinguishable.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the count alone.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dma_io_peripheral.sv
// Device end of a single DMA channel: FIFO-backed, raises DREQ on a fill or
// free-space threshold and moves one byte per falling I/O strobe under DACK.
module dma_io_peripheral
  import dma_periph_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              enable,
  input  logic              devToMem,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic [DATA_W-1:0] lclWrData,
  input  logic              lclWrValid,
  output logic              lclWrReady,
  output logic [DATA_W-1:0] lclRdData,
  output logic              lclRdValid,
  input  logic              lclRdReady,
  output logic              tcSeen,
  output logic              xferErr
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              dir_q;
  logic              ior_prev_q, iow_prev_q;
  logic [DATA_W-1:0] db_out_q;
  logic              db_oe_q, tc_q, err_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head, fifo_wdata;
  logic [CW-1:0]     fifo_count, count_after;

  logic dev2mem, level_ok, strobe_fall, strobe_blocked;
  logic dma_xfer, dma_err, lcl_wr_fire, lcl_rd_fire, drained, eop_hit;

  assign dev2mem = (dir_q == DIR_DEV2MEM);

  // Request threshold: bytes available to read out, or room available to write in.
  assign level_ok = dev2mem ? (fifo_count >= CW'(THRESHOLD))
                            : ((CW'(DEPTH) - fifo_count) >= CW'(THRESHOLD));

  // A strobe is a high-to-low transition of the direction's own strobe while acknowledged.
  assign strobe_fall    = DACK & (dev2mem ? (ior_prev_q & ~IOR_N) : (iow_prev_q & ~IOW_N));
  assign strobe_blocked = dev2mem ? fifo_empty : fifo_full;
  assign dma_xfer       = strobe_fall & (state_q == ACTIVE) & ~strobe_blocked;
  // A strobe that finds no data/room is a protocol fault in any state.
  assign dma_err        = strobe_fall & strobe_blocked;

  // Local side stays live in every state; nothing is accepted while reset is held.
  assign lclWrReady  = ~RESET & dev2mem & ~fifo_full;
  assign lclRdValid  = ~RESET & (dir_q == DIR_MEM2DEV) & ~fifo_empty;
  assign lclRdData   = fifo_head;
  assign lcl_wr_fire = lclWrValid & lclWrReady;
  assign lcl_rd_fire = lclRdValid & lclRdReady;

  assign fifo_push  = dev2mem ? lcl_wr_fire : dma_xfer;
  assign fifo_pop   = dev2mem ? dma_xfer : lcl_rd_fire;
  assign fifo_wdata = dev2mem ? lclWrData : DB_IN;

  assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  assign drained     = dev2mem ? (count_after == '0) : (count_after == CW'(DEPTH));
  assign eop_hit     = (state_q == ACTIVE) & DACK & ~EOP_N;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (CLK),
    .srst_i  (RESET),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State register plus strobe history, data bus register and sticky flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      dir_q      <= DIR_DEV2MEM;
      ior_prev_q <= 1'b1;
      iow_prev_q <= 1'b1;
      db_out_q   <= '0;
      db_oe_q    <= 1'b0;
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ior_prev_q <= IOR_N;
      iow_prev_q <= IOW_N;
      db_oe_q    <= DACK & ~IOR_N & dev2mem;
      if (state_q == IDLE) dir_q <= devToMem;
      if (dma_xfer && dev2mem) db_out_q <= fifo_head;
      if (eop_hit) tc_q <= 1'b1;
      if (dma_err) err_q <= 1'b1;
    end
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (level_ok) state_d = REQUEST;
        REQUEST: if (DACK) state_d = ACTIVE;
        ACTIVE: begin
          if (eop_hit)                state_d = DONE;
          else if (dma_xfer && drained) state_d = IDLE;
          else if (!DACK)             state_d = level_ok ? REQUEST : IDLE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs: request is held through REQUEST and ACTIVE.
  always_comb begin
    DREQ = 1'b0;
    if (state_q == REQUEST || state_q == ACTIVE) DREQ = 1'b1;
  end

  assign DB_OUT  = db_out_q;
  assign DB_OE   = db_oe_q;
  assign tcSeen  = tc_q;
  assign xferErr = err_q;

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral (DEPTH=16, THRESHOLD=4).
module tb_dma_io_peripheral;
  import dma_periph_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET, enable, devToMem, DACK, IOR_N, IOW_N, EOP_N;
  logic [7:0] DB_IN, lclWrData, DB_OUT, lclRdData;
  logic       DREQ, DB_OE, lclWrValid, lclWrReady, lclRdValid, lclRdReady;
  logic       tcSeen, xferErr;

  int tests_run = 0;
  int tests_failed = 0;

  dma_io_peripheral #(.DEPTH(16), .THRESHOLD(4)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .devToMem(devToMem),
    .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
    .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .lclWrData(lclWrData), .lclWrValid(lclWrValid), .lclWrReady(lclWrReady),
    .lclRdData(lclRdData), .lclRdValid(lclRdValid), .lclRdReady(lclRdReady),
    .tcSeen(tcSeen), .xferErr(xferErr)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    lclWrData  = d;
    lclWrValid = 1'b1;
    tick();
    lclWrValid = 1'b0;
  endtask

  // One IOR_N pulse: low for one edge, then high for one edge.
  task automatic ior_pulse(input string tag, input logic [7:0] exp_data);
    IOR_N = 1'b0;
    tick();
    check_eq({tag, "_oe"}, 32'(DB_OE), 32'd1);
    IOR_N = 1'b1;
    tick();
    check_eq({tag, "_data"}, 32'(DB_OUT), 32'(exp_data));
  endtask

  task automatic iow_pulse(input logic [7:0] d);
    DB_IN = d;
    IOW_N = 1'b0;
    tick();
    IOW_N = 1'b1;
    tick();
  endtask

  task automatic wait_dreq(input string tag);
    int n = 0;
    while (!DREQ && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(DREQ), 32'd1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    RESET = 1'b1; enable = 1'b0; devToMem = 1'b1; DACK = 1'b0;
    IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; DB_IN = 8'h00;
    lclWrData = 8'h00; lclWrValid = 1'b0; lclRdReady = 1'b0;

    // Reset values, observed while reset is still asserted
    tick();
    tick();
    check_eq("rst_dreq", 32'(DREQ), 32'd0);
    check_eq("rst_dbout", 32'(DB_OUT), 32'h00);
    check_eq("rst_dboe", 32'(DB_OE), 32'd0);
    check_eq("rst_wrready", 32'(lclWrReady), 32'd0);
    check_eq("rst_rdvalid", 32'(lclRdValid), 32'd0);
    check_eq("rst_tc", 32'(tcSeen), 32'd0);
    check_eq("rst_err", 32'(xferErr), 32'd0);
    check_eq("rst_count", 32'(dut.fifo_count), 32'd0);
    RESET = 1'b0;
    enable = 1'b1;
    tick();

    // Dev->mem block of four bytes
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
    check_eq("d2m_dreq_lag", 32'(DREQ), 32'd0);
    tick();
    check_eq("d2m_dreq", 32'(DREQ), 32'd1);
    DACK = 1'b1;
    tick();
    check_eq("d2m_active", 32'(dut.state_q), 32'(ACTIVE));
    for (int i = 0; i < 4; i++) ior_pulse($sformatf("d2m_b%0d", i), 8'hA0 + 8'(i));
    check_eq("d2m_count", 32'(dut.fifo_count), 32'd0);
    check_eq("d2m_dreq_end", 32'(DREQ), 32'd0);
    check_eq("d2m_idle", 32'(dut.state_q), 32'(IDLE));

    // Strobe on an empty FIFO under DACK
    IOR_N = 1'b0;
    tick();
    IOR_N = 1'b1;
    tick();
    check_eq("empty_err", 32'(xferErr), 32'd1);
    check_eq("empty_count", 32'(dut.fifo_count), 32'd0);
    check_eq("empty_dbout", 32'(DB_OUT), 32'hA3);
    DACK = 1'b0;
    tick();

    // Reset in the middle of a block
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    wait_dreq("mid_dreq");
    DACK = 1'b1;
    tick();
    ior_pulse("mid_b0", 8'hC0);
    ior_pulse("mid_b1", 8'hC1);
    RESET = 1'b1;
    tick();
    check_eq("mid_rst_dreq", 32'(DREQ), 32'd0);
    check_eq("mid_rst_count", 32'(dut.fifo_count), 32'd0);
    check_eq("mid_rst_tc", 32'(tcSeen), 32'd0);
    check_eq("mid_rst_err", 32'(xferErr), 32'd0);
    RESET = 1'b0;
    DACK = 1'b0;
    tick();

    // Held strobe and DACK withdrawal mid-block
    for (int i = 0; i < 8; i++) push_byte(8'h50 + 8'(i));
    wait_dreq("hold_dreq");
    DACK = 1'b1;
    tick();
    ior_pulse("hold_b0", 8'h50);
    check_eq("hold_count7", 32'(dut.fifo_count), 32'd7);
    IOR_N = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    IOR_N = 1'b1;
    tick();
    check_eq("hold_data", 32'(DB_OUT), 32'h51);
    check_eq("hold_count6", 32'(dut.fifo_count), 32'd6);
    DACK = 1'b0;
    tick();
    check_eq("drop_state", 32'(dut.state_q), 32'(REQUEST));
    check_eq("drop_dreq", 32'(DREQ), 32'd1);
    DACK = 1'b1;
    tick();
    ior_pulse("resume_b2", 8'h52);
    check_eq("resume_count", 32'(dut.fifo_count), 32'd5);
    DACK = 1'b0;
    tick();

    // Mem->dev: fresh FIFO, three writes then EOP
    devToMem = 1'b0;
    do_reset();
    wait_dreq("m2d_dreq");
    DACK = 1'b1;
    tick();
    iow_pulse(8'h11);
    iow_pulse(8'h22);
    iow_pulse(8'h33);
    check_eq("m2d_count", 32'(dut.fifo_count), 32'd3);
    IOR_N = 1'b0;
    tick();
    IOR_N = 1'b1;
    tick();
    check_eq("m2d_wrongdir", 32'(dut.fifo_count), 32'd3);
    check_eq("m2d_wrongdir_err", 32'(xferErr), 32'd0);
    EOP_N = 1'b0;
    tick();
    EOP_N = 1'b1;
    DACK = 1'b0;
    check_eq("m2d_tc", 32'(tcSeen), 32'd1);
    check_eq("m2d_dreq_off", 32'(DREQ), 32'd0);
    check_eq("m2d_done", 32'(dut.state_q), 32'(DONE));
    check_eq("m2d_rdvalid", 32'(lclRdValid), 32'd1);
    check_eq("m2d_rd0", 32'(lclRdData), 32'h11);
    lclRdReady = 1'b1;
    tick();
    check_eq("m2d_rd1", 32'(lclRdData), 32'h22);
    tick();
    check_eq("m2d_rd2", 32'(lclRdData), 32'h33);
    tick();
    lclRdReady = 1'b0;
    check_eq("m2d_drained", 32'(lclRdValid), 32'd0);
    check_eq("m2d_still_done", 32'(dut.state_q), 32'(DONE));
    enable = 1'b0;
    tick();
    check_eq("m2d_idle", 32'(dut.state_q), 32'(IDLE));
    check_eq("m2d_tc_sticky", 32'(tcSeen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required $finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
